// File: rtl/cross_bar_arbiter.sv
// Crossbar mux controller: per-slave round-robin arbitration driving the master/slave select vectors.
// Optional grant watchdog (counter + arb_err pulse) is built only when CROSS_BAR_ARB_TIMEOUT_EN is defined.

package cross_bar_pkg;
    localparam int MASTER_N = 4;
    localparam int SLAVE_N  = 4;
    localparam int ADDR_W   = 32;

    typedef logic [ADDR_W-1:0]               addr_t;
    typedef logic [$clog2(SLAVE_N+1)-1:0]    slave_num_t;
    typedef logic [$clog2(MASTER_N+1)-1:0]   master_num_t;
endpackage

module cross_bar_arbiter #(
    parameter int MASTER_N = cross_bar_pkg::MASTER_N,
    parameter int SLAVE_N  = cross_bar_pkg::SLAVE_N,
    parameter int TIMEOUT  = 256
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [MASTER_N:1]                        master_req,
    input  cross_bar_pkg::addr_t       [MASTER_N:1]  master_addr,
    input  logic [SLAVE_N:1]                         slave_ack,
    output cross_bar_pkg::slave_num_t  [MASTER_N:1]  master_mux,
    output cross_bar_pkg::master_num_t [SLAVE_N:1]   slave_mux,
    output logic [SLAVE_N:1]                         arb_err
);
    // state | meaning
    // IDLE  | slave free; grants the first candidate after ptr_q[s] each cycle
    // BUSY  | slave owned by slave_mux_q[s] until ack, request drop or watchdog
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

    localparam int AW    = $bits(cross_bar_pkg::addr_t);
    localparam int SEL_W = $clog2(SLAVE_N);

    state_e                                  state_q [SLAVE_N:1];
    state_e                                  state_d [SLAVE_N:1];
    cross_bar_pkg::slave_num_t  [MASTER_N:1] master_mux_q, master_mux_d;
    cross_bar_pkg::master_num_t [SLAVE_N:1]  slave_mux_q, slave_mux_d;
    cross_bar_pkg::master_num_t [SLAVE_N:1]  ptr_q, ptr_d;
    cross_bar_pkg::master_num_t [SLAVE_N:1]  grant_m;
    cross_bar_pkg::slave_num_t  [MASTER_N:1] tgt;
    logic [MASTER_N:1]                       cand [SLAVE_N:1];
    logic [SLAVE_N:1]                        grant_vld;
    logic [SLAVE_N:1]                        rel;
    logic [SLAVE_N:1]                        owner_req;
    logic [SLAVE_N:1]                        tmo;
    logic                                    unused_addr;

    assign unused_addr = ^master_addr;

    always_comb begin
        for (int m = 1; m <= MASTER_N; m++) begin
            tgt[m] = cross_bar_pkg::slave_num_t'(master_addr[m][AW-1 -: SEL_W])
                   + cross_bar_pkg::slave_num_t'(1);
        end
    end

    // A master already holding a grant is never a candidate elsewhere, even if its address moved.
    always_comb begin
        for (int s = 1; s <= SLAVE_N; s++) begin
            cand[s] = '0;
            for (int m = 1; m <= MASTER_N; m++) begin
                cand[s][m] = master_req[m]
                           && (tgt[m] == cross_bar_pkg::slave_num_t'(s))
                           && (master_mux_q[m] == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s <= SLAVE_N; s++) begin
                state_q[s] <= ST_IDLE;
                ptr_q[s]   <= cross_bar_pkg::master_num_t'(MASTER_N);
            end
            slave_mux_q  <= '0;
            master_mux_q <= '0;
        end else begin
            for (int s = 1; s <= SLAVE_N; s++) begin
                state_q[s] <= state_d[s];
            end
            ptr_q        <= ptr_d;
            slave_mux_q  <= slave_mux_d;
            master_mux_q <= master_mux_d;
        end
    end

    always_comb begin
        for (int s = 1; s <= SLAVE_N; s++) begin
            state_d[s]   = state_q[s];
            grant_vld[s] = 1'b0;
            grant_m[s]   = '0;
            rel[s]       = 1'b0;
            owner_req[s] = 1'b0;
            case (state_q[s])
                ST_IDLE: begin
                    // k-th position after the pointer, wrapping once past MASTER_N
                    for (int k = 1; k <= MASTER_N; k++) begin
                        for (int m = 1; m <= MASTER_N; m++) begin
                            if (!grant_vld[s] && cand[s][m]
                                && ((int'(ptr_q[s]) + k == m)
                                    || (int'(ptr_q[s]) + k == m + MASTER_N))) begin
                                grant_vld[s] = 1'b1;
                                grant_m[s]   = cross_bar_pkg::master_num_t'(m);
                            end
                        end
                    end
                    if (grant_vld[s]) begin
                        state_d[s] = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int m = 1; m <= MASTER_N; m++) begin
                        if (slave_mux_q[s] == cross_bar_pkg::master_num_t'(m)) begin
                            owner_req[s] = master_req[m];
                        end
                    end
                    rel[s] = slave_ack[s] || !owner_req[s] || tmo[s];
                    if (rel[s]) begin
                        state_d[s] = ST_IDLE;
                    end
                end
                default: state_d[s] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        slave_mux_d  = slave_mux_q;
        master_mux_d = master_mux_q;
        ptr_d        = ptr_q;
        for (int s = 1; s <= SLAVE_N; s++) begin
            if (rel[s]) begin
                slave_mux_d[s] = '0;
                ptr_d[s]       = slave_mux_q[s];
            end else if (grant_vld[s]) begin
                slave_mux_d[s] = grant_m[s];
            end
            for (int m = 1; m <= MASTER_N; m++) begin
                if (rel[s] && (slave_mux_q[s] == cross_bar_pkg::master_num_t'(m))) begin
                    master_mux_d[m] = '0;
                end else if (grant_vld[s] && (grant_m[s] == cross_bar_pkg::master_num_t'(m))) begin
                    master_mux_d[m] = cross_bar_pkg::slave_num_t'(s);
                end
            end
        end
    end

    assign master_mux = master_mux_q;
    assign slave_mux  = slave_mux_q;

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q [SLAVE_N:1];
    logic [SLAVE_N:1] arb_err_q;

    always_comb begin
        for (int s = 1; s <= SLAVE_N; s++) begin
            tmo[s] = (state_q[s] == ST_BUSY) && (cnt_q[s] == CNT_W'(TIMEOUT - 1));
        end
    end

    // Counter parks at zero while idle, so it starts from zero on every new grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s <= SLAVE_N; s++) begin
                cnt_q[s] <= '0;
            end
            arb_err_q <= '0;
        end else begin
            for (int s = 1; s <= SLAVE_N; s++) begin
                if (state_q[s] == ST_IDLE) begin
                    cnt_q[s] <= '0;
                end else begin
                    cnt_q[s] <= cnt_q[s] + 1'b1;
                end
            end
            arb_err_q <= tmo & ~slave_ack;
        end
    end

    assign arb_err = arb_err_q;
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT;

    assign tmo     = '0;
    assign arb_err = '0;
`endif

endmodule

// File: tb/tb_cross_bar_arbiter.sv
// Scoreboard bench for cross_bar_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural arbitration model.

module tb_cross_bar_arbiter;
    localparam int MN  = 4;
    localparam int SN  = 4;
    localparam int TMO = 8;
`ifdef CROSS_BAR_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic                                   clk = 1'b0;
    logic                                   rst;
    logic [MN:1]                            master_req;
    cross_bar_pkg::addr_t       [MN:1]      master_addr;
    logic [SN:1]                            slave_ack;
    cross_bar_pkg::slave_num_t  [MN:1]      master_mux;
    cross_bar_pkg::master_num_t [SN:1]      slave_mux;
    logic [SN:1]                            arb_err;

    always #5 clk = ~clk;

    cross_bar_arbiter #(.MASTER_N(MN), .SLAVE_N(SN), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .master_req  (master_req),
        .master_addr (master_addr),
        .slave_ack   (slave_ack),
        .master_mux  (master_mux),
        .slave_mux   (slave_mux),
        .arb_err     (arb_err)
    );

    typedef struct packed {
        cross_bar_pkg::master_num_t [SN:1] sm;
        cross_bar_pkg::slave_num_t  [MN:1] mm;
        logic [SN:1]                       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Reference state: owner of each slave (0 = free), last owner served, cycles in current grant.
    int own  [1:SN];
    int lst  [1:SN];
    int tcnt [1:SN];

    function automatic int tgt_of(int m);
        cross_bar_pkg::addr_t a;
        a = master_addr[m];
        return int'(a[31:30]) + 1;
    endfunction

    // Next-cycle expectation from the current inputs: free slaves serve the requester
    // nearest after the last-served master; owned slaves release on ack, drop or watchdog.
    task automatic model_push();
        exp_t e;
        int   nown [1:SN];
        bit   busy [1:MN];
        int   best, bd, d;
        bit   to;
        e = '0;
        if (rst) begin
            for (int s = 1; s <= SN; s++) begin
                own[s] = 0; lst[s] = MN; tcnt[s] = 0;
            end
        end else begin
            for (int m = 1; m <= MN; m++) busy[m] = 1'b0;
            for (int s = 1; s <= SN; s++) if (own[s] != 0) busy[own[s]] = 1'b1;
            for (int s = 1; s <= SN; s++) begin
                nown[s] = own[s];
                if (own[s] != 0) begin
                    to = TMO_EN && (tcnt[s] == TMO - 1);
                    if (slave_ack[s] || !master_req[own[s]] || to) begin
                        if (to && !slave_ack[s]) e.err[s] = 1'b1;
                        lst[s]  = own[s];
                        nown[s] = 0;
                    end else begin
                        tcnt[s]++;
                    end
                end else begin
                    best = 0; bd = MN;
                    for (int m = 1; m <= MN; m++) begin
                        if (master_req[m] && !busy[m] && tgt_of(m) == s) begin
                            d = (m - lst[s] - 1 + MN) % MN;
                            if (d < bd) begin bd = d; best = m; end
                        end
                    end
                    nown[s] = best;
                    tcnt[s] = 0;
                end
            end
            for (int s = 1; s <= SN; s++) own[s] = nown[s];
        end
        for (int s = 1; s <= SN; s++) begin
            e.sm[s] = cross_bar_pkg::master_num_t'(own[s]);
            if (own[s] != 0) e.mm[own[s]] = cross_bar_pkg::slave_num_t'(s);
        end
        sb_q.push_back(e);
    endtask

    task automatic step();
        model_push();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_tests++;
                if (slave_mux !== e.sm || master_mux !== e.mm || arb_err !== e.err) begin
                    n_fail++;
                    $display("FAIL sb cycle %0d: slave_mux got %h exp %h, master_mux got %h exp %h, arb_err got %b exp %b",
                             cyc, slave_mux, e.sm, master_mux, e.mm, arb_err, e.err);
                end
            end
        end
    end

    initial begin : stim
        int rr_exp [14];
        int prev;
        bit acked [1:MN];
        rst = 1'b1; master_req = '0; master_addr = '0; slave_ack = '0;
        for (int m = 1; m <= MN; m++) acked[m] = 1'b0;
        @(negedge clk);

        // reset, then M1 -> S3
        step(); step();
        chk("rst_slave_mux", int'(slave_mux), 0);
        chk("rst_master_mux", int'(master_mux), 0);
        chk("rst_arb_err", int'(arb_err), 0);
        rst = 1'b0;
        master_req[1] = 1'b1; master_addr[1] = 32'h8000_0000;
        step();
        chk("first_grant_smux3", int'(slave_mux[3]), 1);
        chk("first_grant_mmux1", int'(master_mux[1]), 3);
        slave_ack[3] = 1'b1;
        step();
        chk("ack_release_smux3", int'(slave_mux[3]), 0);
        chk("ack_release_mmux1", int'(master_mux[1]), 0);
        slave_ack = '0; master_req = '0;
        step();

        // round-robin on S2, ack one cycle after each grant
        rr_exp = '{1, 1, 0, 2, 2, 0, 3, 3, 0, 4, 4, 0, 1, 1};
        for (int m = 1; m <= MN; m++) master_addr[m] = 32'h4000_0000;
        master_req = '1;
        prev = 0;
        for (int i = 0; i < 14; i++) begin
            slave_ack[2] = (own[2] != 0) && (prev != 0);
            prev = own[2];
            step();
            chk($sformatf("rr_cycle%0d", i + 1), int'(slave_mux[2]), rr_exp[i]);
        end
        slave_ack = '0; master_req = '0;
        step(); step();

        // parallel grants M1->S4, M2->S1
        master_addr[1] = 32'hC000_0000; master_addr[2] = 32'h0000_0010;
        master_req = 4'b0011;
        step();
        chk("par_smux4", int'(slave_mux[4]), 1);
        chk("par_smux1", int'(slave_mux[1]), 2);
        chk("par_mmux1", int'(master_mux[1]), 4);
        chk("par_mmux2", int'(master_mux[2]), 1);
        slave_ack[4] = 1'b1; slave_ack[1] = 1'b1;
        step();
        slave_ack = '0; master_req = '0;
        step();

        // early drop, then stray ack on idle slave
        master_addr[3] = 32'h0000_0000; master_req[3] = 1'b1;
        step();
        chk("drop_grant_smux1", int'(slave_mux[1]), 3);
        master_req[3] = 1'b0;
        step();
        chk("drop_smux1", int'(slave_mux[1]), 0);
        chk("drop_mmux3", int'(master_mux[3]), 0);
        slave_ack[1] = 1'b1;
        step();
        chk("stray_slave_mux", int'(slave_mux), 0);
        chk("stray_master_mux", int'(master_mux), 0);
        slave_ack = '0;
        step();

        // reset mid-transaction, then priority restarts at M1
        master_addr[4] = 32'h4000_0000; master_req[4] = 1'b1;
        step();
        chk("mid_grant_smux2", int'(slave_mux[2]), 4);
        rst = 1'b1; master_addr[2] = 32'h4000_0000; master_req[2] = 1'b1;
        step();
        chk("mid_rst_slave_mux", int'(slave_mux), 0);
        chk("mid_rst_master_mux", int'(master_mux), 0);
        rst = 1'b0;
        step();
        chk("post_rst_smux2", int'(slave_mux[2]), 2);
        slave_ack[2] = 1'b1;
        step();
        slave_ack = '0; master_req = '0;
        step(); step();

`ifdef CROSS_BAR_ARB_TIMEOUT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        master_addr[1] = 32'h8000_0000; master_addr[2] = 32'h8000_0000;
        master_req = 4'b0011;
        step();
        chk("tmo_grant_smux3", int'(slave_mux[3]), 1);
        for (int k = 1; k < TMO; k++) begin
            step();
            chk($sformatf("tmo_hold%0d_smux3", k), int'(slave_mux[3]), 1);
            chk($sformatf("tmo_hold%0d_err", k), int'(arb_err), 0);
        end
        step();
        chk("tmo_err3", int'(arb_err[3]), 1);
        chk("tmo_cleared_smux3", int'(slave_mux[3]), 0);
        step();
        chk("tmo_err_pulse", int'(arb_err), 0);
        chk("tmo_next_smux3", int'(slave_mux[3]), 2);
        master_req = '0;
        step(); step();
`endif

        // randomized traffic
        for (int it = 0; it < 3000; it++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int m = 1; m <= MN; m++) begin
                int gs;
                gs = 0;
                for (int s = 1; s <= SN; s++) if (own[s] == m) gs = s;
                if (master_req[m]) begin
                    if (acked[m]) begin
                        if ($urandom_range(0, 1) == 0) master_req[m] = 1'b0;
                        else master_addr[m] = $urandom();
                    end else if (gs != 0 && $urandom_range(0, 39) == 0) begin
                        master_req[m] = 1'b0;
                    end else if (gs != 0 && $urandom_range(0, 19) == 0) begin
                        master_addr[m] = $urandom();
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    master_req[m]  = 1'b1;
                    master_addr[m] = $urandom();
                end
                acked[m] = 1'b0;
            end
            for (int s = 1; s <= SN; s++) begin
                if (own[s] != 0) begin
                    slave_ack[s] = ($urandom_range(0, 9) < 4);
                    if (slave_ack[s]) acked[own[s]] = 1'b1;
                end else begin
                    slave_ack[s] = ($urandom_range(0, 19) == 0);
                end
            end
            step();
        end
        rst = 1'b0; master_req = '0; slave_ack = '0;
        step(); step();

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cross_bar_arbiter.md
# cross_bar_arbiter

Mux controller for the crossbar: decodes each master's target slave from its address and arbitrates round-robin per slave. It drives the `master_mux`/`slave_mux` select vectors that steer the combinational crossbar datapath. Each grant is held for exactly one transaction, which ends on the granted slave's `ack`. The block sits directly upstream of the crossbar mux and shares `cross_bar_pkg` with it.

## Interface
Parameters:
- MASTER_N, cross_bar_pkg::MASTER_N (4): number of masters, indexed 1..MASTER_N.
- SLAVE_N, cross_bar_pkg::SLAVE_N (4): number of slaves, indexed 1..SLAVE_N.
- TIMEOUT, 256: grant watchdog limit in cycles; used only when `CROSS_BAR_ARB_TIMEOUT_EN` is defined.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- master_req  in  [MASTER_N:1]  request per master; held until that master's ack.
- master_addr  in  addr_t [MASTER_N:1]  master address; only the slave-select MSBs are used here.
- slave_ack  in  [SLAVE_N:1]  per-slave ack; a one-cycle pulse ends the transaction.
- master_mux  out  slave_num_t [MASTER_N:1]  slave connected to each master; 0 = none.
- slave_mux  out  master_num_t [SLAVE_N:1]  master connected to each slave; 0 = none.
- arb_err  out  [SLAVE_N:1]  timeout pulse per slave; tied 0 without the macro.

## Operation
- **Target decode.** For master m: `tgt[m] = master_addr[m][$bits(addr_t)-1 -: $clog2(SLAVE_N)] + 1`.
- **Candidate set.** Master m is a candidate for slave s when `master_req[m]` is high and `tgt[m] == s`. Each master is a candidate for at most one slave, so grants never conflict.
- **Per-slave FSM.** Each slave has its own state machine with states IDLE and BUSY.
- **IDLE.**
  - If any candidate exists, grant the first candidate after `ptr[s]` in circular order 1..MASTER_N.
  - On the grant: `slave_mux[s] <= m`, `master_mux[m] <= s`, state goes to BUSY.
  - With no candidates, the FSM stays in IDLE with `slave_mux[s] = 0`.
- **BUSY, normal end.** On `slave_ack[s] == 1`:
  - clear `slave_mux[s]` and `master_mux[m]`;
  - set `ptr[s] <= m`;
  - return to IDLE.
- **BUSY, early drop.** If the granted master drops `master_req` without an ack (protocol violation), release exactly as for an ack. `ptr[s]` is updated the same way.
- **Ack and release together.** Ack and release in the same cycle is the normal case. Ack is passed through combinationally by the crossbar, so the master sees its ack in that cycle and the arbiter releases at the following edge.
- **Address changes.** A change of the granted master's address while BUSY is ignored. The grant stays on the original slave until it is released.
- **Stray ack.** `slave_ack` while the slave's FSM is IDLE is ignored.
- **Reset.** `rst` clears everything at the next edge, including mid-transaction:
  - all `master_mux`/`slave_mux` = 0, `arb_err` = 0;
  - all FSMs to IDLE;
  - `ptr[s] = MASTER_N`, so master 1 has highest priority first.

## Timing
- **Grant latency.** `master_req` rising in cycle 0 gives registered mux outputs valid in cycle 1. The slave therefore sees `req` in cycle 1 at the earliest.
- **Turnaround.** An ack in cycle n clears the muxes in cycle n+1. That slave's next grant appears in cycle n+2 at the earliest, giving 1 idle cycle between back-to-back transactions, including a same-master re-request.
- **Independence.** All slaves arbitrate in parallel. Up to min(MASTER_N, SLAVE_N) transactions can be in flight at once.
- **Output registering.** All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- **`CROSS_BAR_ARB_TIMEOUT_EN` defined.**
  - Each slave has a cycle counter: it resets on entry to BUSY and increments every BUSY cycle.
  - When the count reaches TIMEOUT-1 without an ack, the grant is force-released as for an ack.
  - `arb_err[s]` pulses high for 1 cycle, aligned with the cleared mux.
  - `ptr[s]` advances past the stuck master so other requesters get through.
- **Undefined.** No counter is built, `arb_err` is constant 0, and a grant is held indefinitely.

## Test plan
- **Reset values.** Assert `rst` for 2 cycles -> all mux outputs = 0 and `arb_err` = 0. Then M1 requests an address with MSBs 2'b10 -> `slave_mux[3] = 1` and `master_mux[1] = 3` in the next cycle.
- **Round-robin.** M1–M4 all request S2 continuously, with the slave acking each transaction 1 cycle after its grant -> grant order 1,2,3,4,1, with 1 idle cycle (`slave_mux[2] = 0`) between grants.
- **Parallel grants.** M1->S4 and M2->S1 request in the same cycle -> both grants in the next cycle: `slave_mux[4] = 1`, `slave_mux[1] = 2`.
- **Early drop and stray ack.**
  - M3 is granted S1, then drops `req` without an ack -> `slave_mux[1] = 0` in the next cycle.
  - A stray `slave_ack[1]` while S1 is IDLE -> no output change.
- **Reset mid-transaction.** `rst` pulsed while S2 is BUSY with M4 -> all muxes 0 in the next cycle. With M2 and M4 requesting S2 after reset -> M2 is granted first.
- **Timeout (macro defined, TIMEOUT = 8).** M1 is granted S3 and no ack arrives -> `arb_err[3] = 1` for 1 cycle, 8 cycles after the grant, with `slave_mux[3] = 0`. A pending M2 request for S3 is granted next.
